tie_value_bank: RTL and testbench
=================================

Name: tie_value_bank

Overview:
- Parametrised successor to the fixed tie-cell drivers.
- Drives WIDTH tie-off constants from registers rather than hard 1'b0/1'b1 nets, so a value can be reprogrammed post-reset, scanned, and frozen.
- Shadow register loads via masked parallel writes or via a scan chain (se/si/so); an apply strobe moves the shadow into the active register after a fixed latency.
- A sticky lock freezes functional updates. Sits at sub-block boundaries wherever tie constants are instantiated today.

Parameters:
- WIDTH, 8, number of tie outputs (1..64).
- RESET_VALUE, 8'hA5 (WIDTH bits), value of shadow and active after reset.
- APPLY_LATENCY, 2, cycles from accepted apply to active update (1..15).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- se  input  1  scan enable; 1 = shadow acts as shift register.
- si  input  1  scan serial in.
- so  output  1  scan serial out = shadow[WIDTH-1].
- wr_en  input  1  parallel write strobe.
- wr_data  input  WIDTH  write data.
- wr_mask  input  WIDTH  per-bit write enable.
- apply  input  1  request copy shadow -> active.
- lock  input  1  set sticky lock.
- tie_out  output  WIDTH  tie values = active register.
- busy  output  1  apply in flight.
- dirty  output  1  shadow != active (registered compare).
- locked  output  1  lock state.

Behaviour:
- Clock is clk. Reset is rst: synchronous and active-high, sampled on the rising edge of clk.
- Reset state: shadow=active=RESET_VALUE, so=RESET_VALUE[WIDTH-1], busy=0, dirty=0, locked=0, latency counter=0, snapshot=RESET_VALUE. Reset wins over every other input, including mid-apply: the pending apply is discarded.
- Scan mode (se=1):
  - shadow <= {shadow[WIDTH-2:0], si} every cycle, regardless of locked.
  - wr_en is ignored. apply is not accepted.
  - An apply already in flight continues from its snapshot. active never changes due to shifting.
  - For WIDTH=1, shadow <= si.
- Functional write (se=0, wr_en=1, locked=0): shadow <= (shadow & ~wr_mask) | (wr_data & wr_mask). When locked=1, the write is ignored.
- Apply accept (se=0, apply=1, locked=0, busy=0):
  - snapshot <= shadow (value before any same-cycle write).
  - counter <= APPLY_LATENCY-1. busy <= 1.
- Apply in flight:
  - Each cycle with busy=1: if counter==0, active <= snapshot and busy <= 0; else counter decrements.
  - Net effect: an apply accepted at edge N updates tie_out at edge N+APPLY_LATENCY. For APPLY_LATENCY=1, update at N+1.
- Ignored applies:
  - apply while busy=1 or locked=1 is dropped. There is no queueing.
  - apply in the same cycle busy falls is dropped (busy is checked as registered).
- Lock:
  - lock=1 sets locked <= 1, which stays set until rst.
  - lock and apply in the same cycle with locked=0: the apply is accepted, because the registered locked value is used.
  - An in-flight apply completes even if lock asserts afterwards.
- dirty <= (shadow_next != active_next); it is registered, so it reflects state after the edge.
- tie_out is driven straight from the active flops, with no combinational path from inputs.
- Simultaneous wr_en and apply: the apply snapshots the old shadow, and the write lands in shadow; dirty=1 afterwards if the values differ.

Test Plan:
- Reset with WIDTH=8, RESET_VALUE=A5, APPLY_LATENCY=2 -> tie_out=A5, so=1, busy=0, dirty=0, locked=0.
- wr_en, data=3C, mask=0F, then apply next cycle -> shadow=AC, dirty=1; busy high 2 cycles; tie_out=AC exactly 2 edges after apply; dirty=0.
- se=1, shift 8 cycles with si pattern 1,1,1,1,0,0,0,0 -> shadow=F0, so outputs old A5 bits MSB-first (1,0,1,0,0,1,0,1), tie_out stays A5; then se=0 and apply -> tie_out=F0.
- Same-cycle wr_en(FF, mask FF) + apply on shadow=A5 -> tie_out=A5 after latency, shadow=FF, dirty=1. A second apply during busy is dropped: tie_out is not FF until a later apply.
- lock=1 with apply in the same cycle (shadow=5A) -> tie_out=5A after latency; subsequent wr_en/apply ignored, locked=1, tie_out stays 5A; scan still shifts shadow.
- rst asserted one cycle after apply accept -> busy=0, tie_out=A5, locked=0, and no late update occurs.

Source files
------------

// File: rtl/tie_value_bank.sv
`default_nettype none
//==============================================================================
// Module      : tie_value_bank
// Description : Register-based bank of WIDTH tie-off constants. A shadow
//               register is loaded by masked parallel writes or by a scan
//               chain. An apply strobe copies a snapshot of the shadow into
//               the active register after APPLY_LATENCY cycles. A sticky lock
//               freezes functional updates until reset.
//
// Ports       : clk      - clock, all state updates on its rising edge
//               rst      - synchronous active-high reset
//               se       - scan enable (shadow becomes a shift register)
//               si       - scan serial in
//               so       - scan serial out (shadow MSB)
//               wr_en    - parallel write strobe
//               wr_data  - parallel write data
//               wr_mask  - per-bit write enable
//               apply    - request shadow -> active copy
//               lock     - set sticky lock
//               tie_out  - tie values (active register)
//               busy     - apply in flight
//               dirty    - registered shadow != active flag
//               locked   - lock state
//
// Revision    : 1.0 - initial release
//==============================================================================
module tie_value_bank #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE   = WIDTH'(8'hA5),
    parameter int               APPLY_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             se,
    input  logic             si,
    output logic             so,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             apply,
    input  logic             lock,
    output logic [WIDTH-1:0] tie_out,
    output logic             busy,
    output logic             dirty,
    output logic             locked
);

    localparam logic [3:0] c_cnt_load = 4'(APPLY_LATENCY - 1);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_snapshot;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic             r_dirty;
    logic             r_locked;

    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_shadow_next;
    logic [WIDTH-1:0] w_active_next;
    logic [WIDTH-1:0] w_snapshot_next;
    logic [3:0]       w_cnt_next;
    logic             w_busy_next;
    logic             w_accept;
    logic             w_complete;

    // Scan shift value; a one-bit bank simply loads si.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_shift = si;
        end else begin : g_shift_wn
            assign w_shift = {r_shadow[WIDTH-2:0], si};
        end
    endgenerate

    // Apply acceptance uses registered busy/locked, so an apply in the cycle
    // busy falls, or in the cycle lock is first raised, sees the old state.
    assign w_accept   = !se && apply && !r_locked && !r_busy;
    assign w_complete = r_busy && (r_cnt == 4'd0);

    always_comb begin
        w_shadow_next = r_shadow;
        if (se) begin
            w_shadow_next = w_shift;
        end else if (wr_en && !r_locked) begin
            w_shadow_next = (r_shadow & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_comb begin
        w_active_next   = r_active;
        w_snapshot_next = r_snapshot;
        w_cnt_next      = r_cnt;
        w_busy_next     = r_busy;
        if (w_accept) begin
            // Snapshot is the pre-write shadow; a same-cycle write lands
            // only in the shadow.
            w_snapshot_next = r_shadow;
            w_cnt_next      = c_cnt_load;
            w_busy_next     = 1'b1;
        end else if (w_complete) begin
            w_active_next   = r_snapshot;
            w_busy_next     = 1'b0;
        end else if (r_busy) begin
            w_cnt_next      = r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow   <= RESET_VALUE;
            r_active   <= RESET_VALUE;
            r_snapshot <= RESET_VALUE;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_dirty    <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_shadow   <= w_shadow_next;
            r_active   <= w_active_next;
            r_snapshot <= w_snapshot_next;
            r_cnt      <= w_cnt_next;
            r_busy     <= w_busy_next;
            r_dirty    <= (w_shadow_next != w_active_next);
            r_locked   <= r_locked | lock;
        end
    end

    assign so      = r_shadow[WIDTH-1];
    assign tie_out = r_active;
    assign busy    = r_busy;
    assign dirty   = r_dirty;
    assign locked  = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_tie_value_bank.sv
`default_nettype none
//==============================================================================
// Module      : tb_tie_value_bank
// Description : Self-checking bench for tie_value_bank (WIDTH=8, A5, lat 2).
//               Reference model tracks pending applies by due time.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_tie_value_bank;

    localparam int         c_lat   = 2;
    localparam logic [7:0] c_reset = 8'hA5;

    logic       clk;
    logic       rst;
    logic       se;
    logic       si;
    logic       so;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] wr_mask;
    logic       apply;
    logic       lock;
    logic [7:0] tie_out;
    logic       busy;
    logic       dirty;
    logic       locked;

    int n_pass;
    int n_total;

    // Reference model state
    logic [7:0] m_shadow;
    logic [7:0] m_active;
    logic [7:0] m_pend_val;
    bit         m_pend;
    int         m_due;
    int         m_t;
    bit         m_locked;
    bit         m_dirty;

    tie_value_bank #(
        .WIDTH         (8),
        .RESET_VALUE   (c_reset),
        .APPLY_LATENCY (c_lat)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .se      (se),
        .si      (si),
        .so      (so),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_mask (wr_mask),
        .apply   (apply),
        .lock    (lock),
        .tie_out (tie_out),
        .busy    (busy),
        .dirty   (dirty),
        .locked  (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic [7:0] new_shadow;
        bit         was_busy;
        m_t++;
        if (rst) begin
            m_shadow = c_reset;
            m_active = c_reset;
            m_pend   = 1'b0;
            m_locked = 1'b0;
            m_dirty  = 1'b0;
        end else begin
            was_busy = m_pend;
            if (se)
                new_shadow = {m_shadow[6:0], si};
            else if (wr_en && !m_locked)
                new_shadow = (m_shadow & ~wr_mask) | (wr_data & wr_mask);
            else
                new_shadow = m_shadow;
            if (m_pend && m_t == m_due) begin
                m_active = m_pend_val;
                m_pend   = 1'b0;
            end
            if (!se && apply && !m_locked && !was_busy) begin
                m_pend     = 1'b1;
                m_pend_val = m_shadow;
                m_due      = m_t + c_lat;
            end
            m_shadow = new_shadow;
            m_locked = m_locked | lock;
            m_dirty  = (m_shadow != m_active);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; se = 0; si = 0; wr_en = 0; wr_data = 0; wr_mask = 0;
        apply = 0; lock = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (tie_out !== 8'hA5) $display("FAIL reset_tie act=%h req=%h", tie_out, 8'hA5); else n_pass++;
        n_total++; if (so !== 1'b1) $display("FAIL reset_so act=%b req=1", so); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy act=%b req=0", busy); else n_pass++;
        n_total++; if (dirty !== 1'b0) $display("FAIL reset_dirty act=%b req=0", dirty); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL reset_locked act=%b req=0", locked); else n_pass++;
    endtask

    task automatic test_masked_write();
        do_reset();
        wr_en = 1; wr_data = 8'h3C; wr_mask = 8'h0F;
        step();
        n_total++; if (dirty !== 1'b1) $display("FAIL mw_dirty act=%b req=1", dirty); else n_pass++;
        n_total++; if (m_shadow !== 8'hAC || so !== 1'b1) $display("FAIL mw_shadow act_so=%b model=%h req=AC", so, m_shadow); else n_pass++;
        apply = 1;
        step();
        n_total++; if (busy !== 1'b1 || tie_out !== 8'hA5) $display("FAIL mw_edge1 busy=%b tie=%h req busy=1 tie=A5", busy, tie_out); else n_pass++;
        step();
        n_total++; if (busy !== 1'b1 || tie_out !== 8'hA5) $display("FAIL mw_edge1b busy=%b tie=%h req busy=1 tie=A5", busy, tie_out); else n_pass++;
        step();
        n_total++; if (tie_out !== 8'hAC) $display("FAIL mw_tie act=%h req=AC", tie_out); else n_pass++;
        n_total++; if (busy !== 1'b0 || dirty !== 1'b0) $display("FAIL mw_done busy=%b dirty=%b req 0/0", busy, dirty); else n_pass++;
    endtask

    task automatic test_scan();
        logic [7:0] si_pat;
        logic [7:0] so_exp;
        si_pat = 8'b11110000;
        so_exp = 8'hA5;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            se = 1; si = si_pat[7-i];
            n_total++; if (so !== so_exp[7-i]) $display("FAIL scan_so[%0d] act=%b req=%b", i, so, so_exp[7-i]); else n_pass++;
            step();
            n_total++; if (tie_out !== 8'hA5) $display("FAIL scan_tie[%0d] act=%h req=A5", i, tie_out); else n_pass++;
        end
        n_total++; if (dirty !== 1'b1 || so !== 1'b1) $display("FAIL scan_dirty dirty=%b so=%b req 1/1", dirty, so); else n_pass++;
        apply = 1;
        step();
        step();
        step();
        n_total++; if (tie_out !== 8'hF0) $display("FAIL scan_apply act=%h req=F0", tie_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr_en = 1; wr_data = 8'hFF; wr_mask = 8'hFF; apply = 1;
        step();
        apply = 1;              // dropped: busy
        step();
        step();
        n_total++; if (tie_out !== 8'hA5 || dirty !== 1'b1) $display("FAIL b2b_first tie=%h dirty=%b req A5/1", tie_out, dirty); else n_pass++;
        for (int i = 0; i < 3; i++) step();
        n_total++; if (tie_out !== 8'hA5 || busy !== 1'b0) $display("FAIL b2b_drop tie=%h busy=%b req A5/0", tie_out, busy); else n_pass++;
        apply = 1;
        step();
        step();
        step();
        n_total++; if (tie_out !== 8'hFF || dirty !== 1'b0) $display("FAIL b2b_later tie=%h dirty=%b req FF/0", tie_out, dirty); else n_pass++;
    endtask

    task automatic test_lock();
        do_reset();
        wr_en = 1; wr_data = 8'h5A; wr_mask = 8'hFF;
        step();
        lock = 1; apply = 1;
        step();
        n_total++; if (locked !== 1'b1 || busy !== 1'b1) $display("FAIL lock_set locked=%b busy=%b req 1/1", locked, busy); else n_pass++;
        step();
        step();
        n_total++; if (tie_out !== 8'h5A) $display("FAIL lock_apply act=%h req=5A", tie_out); else n_pass++;
        wr_en = 1; wr_data = 8'h00; wr_mask = 8'hFF;
        step();
        apply = 1;
        step();
        for (int i = 0; i < 3; i++) step();
        n_total++; if (tie_out !== 8'h5A || busy !== 1'b0 || dirty !== 1'b0) $display("FAIL lock_frozen tie=%h busy=%b dirty=%b req 5A/0/0", tie_out, busy, dirty); else n_pass++;
        se = 1; si = 1'b1;
        step();
        // 5A shifted left with si=1 -> B5, MSB now 1 and differs from active
        n_total++; if (so !== 1'b1 || dirty !== 1'b1 || locked !== 1'b1) $display("FAIL lock_scan so=%b dirty=%b locked=%b req 1/1/1", so, dirty, locked); else n_pass++;
    endtask

    task automatic test_reset_mid_apply();
        do_reset();
        wr_en = 1; wr_data = 8'h00; wr_mask = 8'hFF;
        step();
        apply = 1; lock = 1;
        step();
        rst = 1;
        step();
        n_total++; if (busy !== 1'b0 || tie_out !== 8'hA5 || locked !== 1'b0) $display("FAIL rma_reset busy=%b tie=%h locked=%b req 0/A5/0", busy, tie_out, locked); else n_pass++;
        for (int i = 0; i < 4; i++) step();
        n_total++; if (tie_out !== 8'hA5 || dirty !== 1'b0) $display("FAIL rma_late tie=%h dirty=%b req A5/0", tie_out, dirty); else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            se      = ($urandom_range(0, 3) == 0);
            si      = 1'($urandom);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = 8'($urandom);
            wr_mask = 8'($urandom);
            apply   = ($urandom_range(0, 2) == 0);
            lock    = ($urandom_range(0, 79) == 0);
            step();
            n_total++;
            if (tie_out !== m_active || so !== m_shadow[7] || busy !== m_pend ||
                dirty !== m_dirty || locked !== m_locked) begin
                if (errs < 10)
                    $display("FAIL rand[%0d] tie=%h/%h so=%b/%b busy=%b/%b dirty=%b/%b locked=%b/%b (act/req)",
                             i, tie_out, m_active, so, m_shadow[7], busy, m_pend,
                             dirty, m_dirty, locked, m_locked);
                errs++;
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_t     = 0;
        m_pend  = 1'b0;
        m_due   = 0;
        m_pend_val = c_reset;
        m_shadow = c_reset;
        m_active = c_reset;
        m_locked = 1'b0;
        m_dirty  = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_masked_write();
        test_scan();
        test_back_to_back();
        test_lock();
        test_reset_mid_apply();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
